multi_channel_counter: RTL and testbench
========================================

Name: multi_channel_counter

Overview:
Parametrised bank of NUM_CH independent up-counters on a single clock. Each channel has its own clock-enable and a programmable prescaler, so one clock domain emulates many slower per-channel count rates. Adds synchronous clear, a single-channel load port, wrap/saturate mode and a sticky overflow flag per channel. Used as a multi-rate event/tick counter for clocking and stimulus testbenches.

Parameters:
NUM_CH, 6, number of counter channels (1..32)
WIDTH, 32, counter width in bits (2..64)
DIV_W, 8, prescaler divide-value width in bits (1..16)
CH_W, $clog2(NUM_CH) (min 1), width of the load channel index

Ports:
clk  input  1  sole clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
en  input  NUM_CH  per-channel count enable
div  input  NUM_CH*DIV_W  per-channel divide value; channel i uses bits [i*DIV_W +: DIV_W]; tick every div+1 enabled cycles
sat_mode  input  NUM_CH  per-channel mode: 0 = wrap, 1 = saturate
clr  input  NUM_CH  per-channel synchronous clear of counter and prescaler
load_valid  input  1  load strobe
load_ch  input  CH_W  channel addressed by load
load_data  input  WIDTH  value to load
ovf_clr  input  NUM_CH  per-channel clear of sticky overflow flag
count  output  NUM_CH*WIDTH  counter values; channel i at [i*WIDTH +: WIDTH]
ovf  output  NUM_CH  sticky overflow flags
tick  output  NUM_CH  registered: 1 for one cycle after a channel's counter incremented or saturated-held on a tick

Behaviour:
- Reset (rst=1, asynchronous): count=0, prescaler=0, ovf=0, tick=0 for all channels. These values hold while rst is high. The first update occurs on the first posedge after deassertion.
- Per channel i, on each posedge, evaluate in priority order: clr > load > tick.
- clr[i]=1: count_i<=0, pre_i<=0, tick_i<=0. ovf_i is unaffected except by ovf_clr.
- Load: if load_valid=1, load_ch=i and clr[i]=0, then count_i<=load_data and pre_i<=0. There is no increment that cycle. load_ch>=NUM_CH is ignored.
- Prescaler: when en[i]=1, a tick condition exists if pre_i>=div_i.
  - On a tick condition, pre_i<=0; otherwise pre_i<=pre_i+1.
  - When en[i]=0, pre_i holds.
  - div_i=0 gives a tick every enabled cycle.
  - The >= compare makes a mid-count decrease of div take effect immediately, with no missed wrap.
- Tick action, when not cleared or loaded:
  - Wrap mode, count_i != all-ones: count_i<=count_i+1.
  - Wrap mode, count_i == all-ones: count_i<=0 and ovf_i<=1.
  - Saturate mode, count_i == all-ones: count_i holds and ovf_i<=1.
- tick_i is registered and asserts in the cycle after any tick action, including a saturated hold. It is 0 otherwise.
- ovf_i: set has priority over ovf_clr[i] in the same cycle. Otherwise ovf_clr[i]=1 clears it. Neither clr nor load affects ovf.
- Latency: count, ovf and tick reflect an event one cycle after the posedge where the condition was sampled. There is no combinational path from inputs to outputs.
- Changing sat_mode takes effect on the next tick. Changing it does not alter count.
- Channels are fully independent. Simultaneous events on different channels never interact, apart from the single shared load port.

Test Plan:
- Reset/basic: rst pulse mid-count with en=all-ones and div=0 -> outputs return to 0 immediately, asynchronously. After release, channel 0 reads 1,2,3 on successive cycles and tick[0] stays high.
- Prescaler: div_2=3, en[2]=1 for 12 cycles -> count_2=3 with ticks every 4th cycle. div_2 changed to 1 while pre_2=2 -> tick on the next edge, then period 2.
- Wrap/overflow: WIDTH=8, load 0xFE into channel 1, wrap mode, div=0 -> count 0xFF, then 0x00 with ovf[1]=1. ovf[1] stays set until ovf_clr[1]. Asserting ovf_clr in the same cycle as a new overflow leaves ovf=1.
- Saturate: channel 3 loaded with 0xFF, sat_mode=1 -> count holds at 0xFF, ovf[3]=1 and tick[3] pulses on each tick.
- Priority: clr[4], load to channel 4 (0x55) and a tick condition in the same cycle -> count_4=0. Load plus tick without clr -> count_4=0x55 with no increment. load_ch=NUM_CH -> no channel changes.
- Enable gating: en[5] dropped with pre_5=2 and div=4, held low for 10 cycles -> count_5 and pre_5 frozen. When en[5] returns, the tick occurs 2 enabled cycles later.

Source files
------------

// File: rtl/multi_channel_counter.sv
// Bank of independent prescaled up-counters sharing one clock.
// Each channel has wrap/saturate mode, a sticky overflow flag and a registered tick.
module multi_channel_counter #(
    parameter int NUM_CH = 6,
    parameter int WIDTH  = 32,
    parameter int DIV_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         en,
    input  logic [NUM_CH*DIV_W-1:0]   div,
    input  logic [NUM_CH-1:0]         sat_mode,
    input  logic [NUM_CH-1:0]         clr,
    input  logic                      load_valid,
    input  logic [CH_W-1:0]           load_ch,
    input  logic [WIDTH-1:0]          load_data,
    input  logic [NUM_CH-1:0]         ovf_clr,
    output logic [NUM_CH*WIDTH-1:0]   count,
    output logic [NUM_CH-1:0]         ovf,
    output logic [NUM_CH-1:0]         tick
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [DIV_W-1:0] pre_q;
        logic             ovf_q;
        logic             tick_q;
        logic [DIV_W-1:0] div_ch;
        logic             load_hit;
        logic             tick_cond;
        logic             at_max;
        logic             ovf_set;

        assign div_ch    = div[i*DIV_W +: DIV_W];
        // load_ch values at or beyond NUM_CH never match any channel
        assign load_hit  = load_valid && (load_ch == CH_W'(i));
        assign tick_cond = en[i] && (pre_q >= div_ch);
        assign at_max    = &cnt_q;
        assign ovf_set   = !clr[i] && !load_hit && tick_cond && at_max;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                pre_q  <= '0;
                tick_q <= 1'b0;
            end else begin
                tick_q <= 1'b0;
                if (clr[i]) begin
                    cnt_q <= '0;
                    pre_q <= '0;
                end else if (load_hit) begin
                    cnt_q <= load_data;
                    pre_q <= '0;
                end else if (en[i]) begin
                    if (tick_cond) begin
                        pre_q  <= '0;
                        tick_q <= 1'b1;
                        if (!at_max)
                            cnt_q <= cnt_q + 1'b1;
                        else if (!sat_mode[i])
                            cnt_q <= '0;
                    end else begin
                        pre_q <= pre_q + 1'b1;
                    end
                end
            end
        end

        // a new overflow wins over a same-cycle clear request
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                ovf_q <= 1'b0;
            else if (ovf_set)
                ovf_q <= 1'b1;
            else if (ovf_clr[i])
                ovf_q <= 1'b0;
        end

        assign count[i*WIDTH +: WIDTH] = cnt_q;
        assign ovf[i]                  = ovf_q;
        assign tick[i]                 = tick_q;
    end

endmodule

// File: tb/tb_multi_channel_counter.sv
// Directed self-checking bench for multi_channel_counter (6 channels, 8-bit counters).
module tb_multi_channel_counter;

    localparam int NUM_CH = 6;
    localparam int WIDTH  = 8;
    localparam int DIV_W  = 8;
    localparam int CH_W   = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH*DIV_W-1:0] div;
    logic [NUM_CH-1:0]       sat_mode;
    logic [NUM_CH-1:0]       clr;
    logic                    load_valid;
    logic [CH_W-1:0]         load_ch;
    logic [WIDTH-1:0]        load_data;
    logic [NUM_CH-1:0]       ovf_clr;
    logic [NUM_CH*WIDTH-1:0] count;
    logic [NUM_CH-1:0]       ovf;
    logic [NUM_CH-1:0]       tick;

    int checks   = 0;
    int failures = 0;

    multi_channel_counter #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DIV_W(DIV_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .div(div), .sat_mode(sat_mode),
        .clr(clr), .load_valid(load_valid), .load_ch(load_ch),
        .load_data(load_data), .ovf_clr(ovf_clr),
        .count(count), .ovf(ovf), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ch_cnt(input int c);
        return count[c*WIDTH +: WIDTH];
    endfunction

    initial begin
        rst = 1'b1; en = '0; div = '0; sat_mode = '0; clr = '0;
        load_valid = 1'b0; load_ch = '0; load_data = '0; ovf_clr = '0;
        repeat (2) step();
        chk("reset_count", 64'(count), 64'h0);
        chk("reset_ovf",   64'(ovf),   64'h0);
        chk("reset_tick",  64'(tick),  64'h0);

        // basic counting with div=0 on all channels
        rst = 1'b0;
        en  = '1;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("basic_cnt0_%0d", k), 64'(ch_cnt(0)), 64'(k));
            chk($sformatf("basic_tick0_%0d", k), 64'(tick[0]), 64'h1);
        end
        // asynchronous reset in mid-cycle
        rst = 1'b1;
        #2;
        chk("async_rst_count", 64'(count), 64'h0);
        chk("async_rst_tick",  64'(tick),  64'h0);
        rst = 1'b0;
        step();
        chk("post_rst_cnt0", 64'(ch_cnt(0)), 64'h1);
        en  = '0;
        clr = '1;
        step();
        clr = '0;
        chk("clr_all", 64'(count), 64'h0);
        chk("clr_all_tick", 64'(tick), 64'h0);

        // prescaler on channel 2, div=3
        div[2*DIV_W +: DIV_W] = 8'd3;
        en[2] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("pre_tick2_%0d", k), 64'(tick[2]), 64'(((k + 1) % 4) == 0));
        end
        chk("pre_cnt2_12", 64'(ch_cnt(2)), 64'h3);
        step();
        step();
        div[2*DIV_W +: DIV_W] = 8'd1;
        step();
        chk("div_drop_tick", 64'(tick[2]), 64'h1);
        chk("div_drop_cnt",  64'(ch_cnt(2)), 64'h4);
        step();
        chk("div1_gap", 64'(tick[2]), 64'h0);
        step();
        chk("div1_tick", 64'(tick[2]), 64'h1);
        chk("div1_cnt",  64'(ch_cnt(2)), 64'h5);
        en[2] = 1'b0;

        // wrap and sticky overflow on channel 1
        en[1] = 1'b1; load_valid = 1'b1; load_ch = 3'd1; load_data = 8'hFE;
        step();
        load_valid = 1'b0;
        chk("wrap_load",      64'(ch_cnt(1)), 64'hFE);
        chk("wrap_load_tick", 64'(tick[1]),   64'h0);
        step();
        chk("wrap_ff",     64'(ch_cnt(1)), 64'hFF);
        chk("wrap_ff_ovf", 64'(ovf[1]),    64'h0);
        step();
        chk("wrap_00",      64'(ch_cnt(1)), 64'h00);
        chk("wrap_ovf",     64'(ovf[1]),    64'h1);
        chk("wrap_tick",    64'(tick[1]),   64'h1);
        en[1] = 1'b0;
        step();
        chk("ovf_sticky", 64'(ovf[1]), 64'h1);
        ovf_clr[1] = 1'b1;
        step();
        ovf_clr[1] = 1'b0;
        chk("ovf_cleared", 64'(ovf[1]), 64'h0);
        load_valid = 1'b1; load_ch = 3'd1; load_data = 8'hFF;
        step();
        load_valid = 1'b0;
        en[1] = 1'b1; ovf_clr[1] = 1'b1;
        step();
        en[1] = 1'b0; ovf_clr[1] = 1'b0;
        chk("ovf_set_wins", 64'(ovf[1]),    64'h1);
        chk("ovf_set_cnt",  64'(ch_cnt(1)), 64'h00);

        // saturate on channel 3
        sat_mode[3] = 1'b1;
        load_valid = 1'b1; load_ch = 3'd3; load_data = 8'hFF;
        step();
        load_valid = 1'b0;
        en[3] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("sat_cnt_%0d", k),  64'(ch_cnt(3)), 64'hFF);
            chk($sformatf("sat_tick_%0d", k), 64'(tick[3]),   64'h1);
            chk($sformatf("sat_ovf_%0d", k),  64'(ovf[3]),    64'h1);
        end
        en[3] = 1'b0;
        sat_mode[3] = 1'b0;
        step();
        chk("sat_idle_tick", 64'(tick[3]),   64'h0);
        chk("mode_chg_cnt",  64'(ch_cnt(3)), 64'hFF);

        // priority on channel 4
        en[4] = 1'b1;
        repeat (3) step();
        chk("prio_pre", 64'(ch_cnt(4)), 64'h3);
        clr[4] = 1'b1; load_valid = 1'b1; load_ch = 3'd4; load_data = 8'h55;
        step();
        clr[4] = 1'b0;
        chk("prio_clr",      64'(ch_cnt(4)), 64'h00);
        chk("prio_clr_tick", 64'(tick[4]),   64'h0);
        step();
        load_valid = 1'b0;
        chk("prio_load",      64'(ch_cnt(4)), 64'h55);
        chk("prio_load_tick", 64'(tick[4]),   64'h0);
        step();
        en[4] = 1'b0;
        chk("prio_after_load", 64'(ch_cnt(4)), 64'h56);
        load_valid = 1'b1; load_ch = 3'd6; load_data = 8'hAA;
        step();
        load_valid = 1'b0;
        chk("load_oob", 64'(count), 64'h0056FF050000);

        // enable gating on channel 5, div=4
        div[5*DIV_W +: DIV_W] = 8'd4;
        en[5] = 1'b1;
        step();
        step();
        en[5] = 1'b0;
        repeat (10) step();
        chk("gate_frozen_cnt",  64'(ch_cnt(5)), 64'h0);
        chk("gate_frozen_tick", 64'(tick[5]),   64'h0);
        en[5] = 1'b1;
        step();
        chk("gate_resume_1", 64'(tick[5]), 64'h0);
        step();
        chk("gate_resume_2", 64'(tick[5]), 64'h0);
        step();
        chk("gate_resume_3", 64'(tick[5]),   64'h1);
        chk("gate_cnt",      64'(ch_cnt(5)), 64'h1);
        en[5] = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
